switch_mcu_regfile: RTL and testbench



---
 rtl/switch_mcu_regfile.sv | 157 +++++++++++++++
 tb/tb_switch_mcu_regfile.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/switch_mcu_regfile.sv
// switch_mcu_regfile: general-purpose register file for the switch core's ALU op units.
//
// 31 writable DATA_W-bit registers (x1..x31) plus hardwired-zero x0, two registered read
// ports, one write port and a sequenced clear engine that zeroes x1..x31, one entry per cycle.
//
// Ports:
//   in_clk                  core clock
//   in_rst                  asynchronous, active-high reset
//   in_ren_1/in_raddr_1     read port 1 request; out_rdata_1 loads one cycle later and holds
//   in_ren_2/in_raddr_2     read port 2 request; out_rdata_2 loads one cycle later and holds
//   in_wen/in_waddr/in_wdata write port (writes to x0 or while clearing are dropped)
//   in_clr                  single-cycle clear request (ignored while clearing)
//   out_busy                clear engine active
//
// Configuration:
//   SWITCH_MCU_REGFILE_BYPASS_EN  defined   -> a same-edge write and read of one nonzero entry
//                                             returns the new data (write-first).
//                                 undefined -> the read returns the old entry value
//                                             (read-first).

module switch_mcu_regfile #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic              in_ren_1,
    input  logic [ADDR_W-1:0] in_raddr_1,
    output logic [DATA_W-1:0] out_rdata_1,
    input  logic              in_ren_2,
    input  logic [ADDR_W-1:0] in_raddr_2,
    output logic [DATA_W-1:0] out_rdata_2,
    input  logic              in_wen,
    input  logic [ADDR_W-1:0] in_waddr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic              in_clr,
    output logic              out_busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [0:0] {
        StIdle,
        StClr
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   index_q, index_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   rdata_1_q, rdata_1_d;
    logic [DATA_W-1:0]   rdata_2_q, rdata_2_d;

    // x0 is not stored; the array starts at entry 1.
    logic [DATA_W-1:0]   regs_q [1:DEPTH-1];
    logic [DATA_W-1:0]   regs_d [1:DEPTH-1];

    logic                wr_accept;
    logic [DATA_W-1:0]   rd_val_1;
    logic [DATA_W-1:0]   rd_val_2;

    assign wr_accept = in_wen && (in_waddr != '0) && (state_q == StIdle);

    // Read muxes: address 0 falls through every compare and returns zero.
    always_comb begin
        rd_val_1 = '0;
        rd_val_2 = '0;
        for (int i = 1; i < int'(DEPTH); i++) begin
            if (in_raddr_1 == ADDR_W'(i)) begin
                rd_val_1 = regs_q[i];
            end
            if (in_raddr_2 == ADDR_W'(i)) begin
                rd_val_2 = regs_q[i];
            end
        end
`ifdef SWITCH_MCU_REGFILE_BYPASS_EN
        // Write-first: forward the data being written this edge. wr_accept already
        // excludes x0, so address 0 still reads zero.
        if (wr_accept && (in_waddr == in_raddr_1)) begin
            rd_val_1 = in_wdata;
        end
        if (wr_accept && (in_waddr == in_raddr_2)) begin
            rd_val_2 = in_wdata;
        end
`endif
    end

    // Next-state: storage, clear sequencing and read-data registers.
    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        busy_d    = busy_q;
        regs_d    = regs_q;
        rdata_1_d = rdata_1_q;
        rdata_2_d = rdata_2_q;

        unique case (state_q)
            StIdle: begin
                for (int i = 1; i < int'(DEPTH); i++) begin
                    if (wr_accept && (in_waddr == ADDR_W'(i))) begin
                        regs_d[i] = in_wdata;
                    end
                end
                if (in_clr) begin
                    state_d = StClr;
                    index_d = ADDR_W'(1);
                    busy_d  = 1'b1;
                end
            end
            StClr: begin
                // Writes and further clear requests are dropped here.
                for (int i = 1; i < int'(DEPTH); i++) begin
                    if (index_q == ADDR_W'(i)) begin
                        regs_d[i] = '0;
                    end
                end
                if (index_q == '1) begin
                    state_d = StIdle;
                    index_d = '0;
                    busy_d  = 1'b0;
                end else begin
                    index_d = index_q + ADDR_W'(1);
                end
            end
        endcase

        // Reads while clearing return zero rather than a partially cleared entry.
        if (in_ren_1) begin
            rdata_1_d = (state_q == StClr) ? '0 : rd_val_1;
        end
        if (in_ren_2) begin
            rdata_2_d = (state_q == StClr) ? '0 : rd_val_2;
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q   <= StIdle;
            index_q   <= '0;
            busy_q    <= 1'b0;
            rdata_1_q <= '0;
            rdata_2_q <= '0;
            regs_q    <= '{default: '0};
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            busy_q    <= busy_d;
            rdata_1_q <= rdata_1_d;
            rdata_2_q <= rdata_2_d;
            regs_q    <= regs_d;
        end
    end

    assign out_rdata_1 = rdata_1_q;
    assign out_rdata_2 = rdata_2_q;
    assign out_busy    = busy_q;

endmodule

// File: tb/tb_switch_mcu_regfile.sv
// Testbench for switch_mcu_regfile: table of directed single-cycle vectors plus
// hand-written sequences for the clear engine and reset during a clear.

module tb_switch_mcu_regfile;

    logic        clk;
    logic        rst;
    logic        ren_1, ren_2, wen, clr;
    logic [4:0]  raddr_1, raddr_2, waddr;
    logic [31:0] wdata;
    logic [31:0] rdata_1, rdata_2;
    logic        busy;

    int n_vec;
    int n_err;

    switch_mcu_regfile #(
        .DATA_W(32),
        .ADDR_W(5)
    ) dut (
        .in_clk     (clk),
        .in_rst     (rst),
        .in_ren_1   (ren_1),
        .in_raddr_1 (raddr_1),
        .out_rdata_1(rdata_1),
        .in_ren_2   (ren_2),
        .in_raddr_2 (raddr_2),
        .out_rdata_2(rdata_2),
        .in_wen     (wen),
        .in_waddr   (waddr),
        .in_wdata   (wdata),
        .in_clr     (clr),
        .out_busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected read data for same-edge write/read of one entry.
`ifdef SWITCH_MCU_REGFILE_BYPASS_EN
    localparam logic [31:0] ExpX7Same = 32'hA5A5_A5A5;
    localparam logic [31:0] ExpX9Same = 32'h0000_0099;
`else
    localparam logic [31:0] ExpX7Same = 32'h0000_0001;
    localparam logic [31:0] ExpX9Same = 32'h0000_0000;
`endif

    typedef struct {
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        ren_1;
        logic [4:0]  raddr_1;
        logic        ren_2;
        logic [4:0]  raddr_2;
        logic [31:0] exp_1;
        logic [31:0] exp_2;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wen = 1'b0; waddr = '0; wdata = '0;
        ren_1 = 1'b0; raddr_1 = '0; ren_2 = 1'b0; raddr_2 = '0;
        clr = 1'b0;
    endtask

    // One rising edge, then sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        idle_inputs();
        wen = 1'b1; waddr = a; wdata = d;
        step();
        idle_inputs();
    endtask

    task automatic do_read(input logic [4:0] a1, input logic [4:0] a2);
        idle_inputs();
        ren_1 = 1'b1; raddr_1 = a1; ren_2 = 1'b1; raddr_2 = a2;
        step();
        idle_inputs();
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        #12;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int busy_cnt;
        logic [31:0] exp;
        n_vec = 0;
        n_err = 0;
        idle_inputs();
        rst = 1'b0;
        #2;
        do_reset();

        // Reset state.
        chk("reset_rdata_1", rdata_1, 32'h0);
        chk("reset_rdata_2", rdata_2, 32'h0);
        chk("reset_busy", {31'h0, busy}, 32'h0);

        // All 32 addresses read zero on both ports after reset.
        for (int i = 0; i < 32; i++) begin
            do_read(5'(i), 5'(31 - i));
            chk("reset_read_1", rdata_1, 32'h0);
            chk("reset_read_2", rdata_2, 32'h0);
        end

        // wen waddr wdata  ren_1 raddr_1  ren_2 raddr_2  exp_1 exp_2
        vecs[0]  = '{1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0};
        vecs[1]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd0, 32'hDEAD_BEEF, 32'h0};
        vecs[2]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd9, 1'b0, 5'd5, 32'hDEAD_BEEF, 32'h0};
        vecs[3]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd1, 1'b0, 5'd2, 32'hDEAD_BEEF, 32'h0};
        vecs[4]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 1'b0, 5'd4, 32'hDEAD_BEEF, 32'h0};
        vecs[5]  = '{1'b1, 5'd0, 32'h1234_5678, 1'b0, 5'd0, 1'b0, 5'd0, 32'hDEAD_BEEF, 32'h0};
        vecs[6]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd5, 32'h0, 32'hDEAD_BEEF};
        vecs[7]  = '{1'b1, 5'd7, 32'h1, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 32'hDEAD_BEEF};
        vecs[8]  = '{1'b1, 5'd7, 32'hA5A5_A5A5, 1'b1, 5'd7, 1'b1, 5'd5, ExpX7Same, 32'hDEAD_BEEF};
        vecs[9]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd0, 32'hA5A5_A5A5, 32'h0};
        vecs[10] = '{1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 1'b1, 5'd9, 32'hA5A5_A5A5, ExpX9Same};
        vecs[11] = '{1'b1, 5'd0, 32'h77, 1'b1, 5'd9, 1'b1, 5'd0, 32'h99, 32'h0};

        for (int v = 0; v < 12; v++) begin
            wen = vecs[v].wen; waddr = vecs[v].waddr; wdata = vecs[v].wdata;
            ren_1 = vecs[v].ren_1; raddr_1 = vecs[v].raddr_1;
            ren_2 = vecs[v].ren_2; raddr_2 = vecs[v].raddr_2;
            clr = 1'b0;
            step();
            chk($sformatf("vec%0d_rdata_1", v), rdata_1, vecs[v].exp_1);
            chk($sformatf("vec%0d_rdata_2", v), rdata_2, vecs[v].exp_2);
            chk($sformatf("vec%0d_busy", v), {31'h0, busy}, 32'h0);
        end
        idle_inputs();

        // Clear engine: fill, clear, drop a mid-clear write, read mid-clear.
        for (int i = 1; i < 32; i++) do_write(5'(i), 32'(i));
        do_read(5'd4, 5'd31);
        chk("fill_x4", rdata_1, 32'd4);
        chk("fill_x31", rdata_2, 32'd31);

        clr = 1'b1;
        step();
        idle_inputs();
        busy_cnt = busy ? 1 : 0;
        for (int c = 1; c <= 40; c++) begin
            idle_inputs();
            if (c == 5) begin
                ren_1 = 1'b1; raddr_1 = 5'd4; ren_2 = 1'b1; raddr_2 = 5'd31;
            end
            if (c == 7) clr = 1'b1;
            if (c == 10) begin
                wen = 1'b1; waddr = 5'd3; wdata = 32'h0000_FFFF;
            end
            step();
            if (c == 5) begin
                chk("midclr_read_1", rdata_1, 32'h0);
                chk("midclr_read_2", rdata_2, 32'h0);
            end
            if (!busy) break;
            busy_cnt++;
            if (c == 40) begin
                n_vec++; n_err++;
                $display("FAIL clr_timeout: busy still %0d after 40 cycles, required 0", busy);
            end
        end
        idle_inputs();
        chk("busy_cycles", 32'(busy_cnt), 32'd31);

        // First edge after busy falls: write accepted, read x3 cleared.
        wen = 1'b1; waddr = 5'd10; wdata = 32'h0000_ABCD;
        ren_1 = 1'b1; raddr_1 = 5'd3; ren_2 = 1'b1; raddr_2 = 5'd31;
        step();
        idle_inputs();
        chk("postclr_x3", rdata_1, 32'h0);
        chk("postclr_x31", rdata_2, 32'h0);
        for (int i = 0; i < 32; i++) begin
            exp = (i == 10) ? 32'h0000_ABCD : 32'h0;
            do_read(5'(i), 5'(i));
            chk($sformatf("postclr_rd1_x%0d", i), rdata_1, exp);
            chk($sformatf("postclr_rd2_x%0d", i), rdata_2, exp);
        end

        // Reset in the middle of a clear.
        do_write(5'd2, 32'h2222_0002);
        do_write(5'd20, 32'h2020_0020);
        do_read(5'd20, 5'd2);
        chk("prerst_x20", rdata_1, 32'h2020_0020);
        clr = 1'b1;
        step();
        idle_inputs();
        for (int c = 1; c < 15; c++) step();
        chk("prerst_busy", {31'h0, busy}, 32'h1);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_busy_now", {31'h0, busy}, 32'h0);
        chk("rst_rdata_1_now", rdata_1, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            do_read(5'(i), 5'(31 - i));
            chk("rst_read_1", rdata_1, 32'h0);
            chk("rst_read_2", rdata_2, 32'h0);
        end
        do_write(5'd20, 32'h5555_5555);
        do_read(5'd20, 5'd2);
        chk("postrst_write", rdata_1, 32'h5555_5555);
        chk("postrst_x2", rdata_2, 32'h0);
        chk("postrst_busy", {31'h0, busy}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
